// File: rtl/vga_pkg.sv
// Shared VGA/sprite definitions: sprite position limits, position width,
// the position-controller FSM encoding and the clamp helper.
package vga_pkg;

   localparam int SPRITE_X_MAX = 960;
   localparam int SPRITE_Y_MAX = 704;
   localparam int POS_W        = 12;

   typedef enum logic {
      PC_IDLE   = 1'b0,
      PC_COMMIT = 1'b1
   } pos_ctrl_state_t;

   function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                  input int unsigned       lim);
      return (32'(v) > lim) ? POS_W'(lim) : v;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index after the
// previous winner, wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] eligible,
   input  logic         en,
   output logic [N-1:0] grant,
   output logic         grant_valid
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] cand;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      last_d      = last_q;
      cand        = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(last_q) + k) % N);
         if (en && !grant_valid && eligible[cand]) begin
            grant_valid = 1'b1;
            grant[cand] = 1'b1;
            last_d      = cand;
         end
      end
   end

   // Reset to N-1 so requester 0 is the first to win.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= IW'(N - 1);
      else     last_q <= last_d;
   end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: arbitrated writes into shadow slots, copied to
// the active outputs on each rising edge of vertical blanking.
//
// state     | meaning
// PC_IDLE   | arbitrate requesters and write the shadow slots
// PC_COMMIT | one cycle: copy shadow to active, no grants
module sprite_pos_ctrl
   import vga_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int NUM_SLOTS = 4,
   parameter int X_MAX     = SPRITE_X_MAX,
   parameter int Y_MAX     = SPRITE_Y_MAX,
   localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                vblnk,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ-1:0][SW-1:0]          req_slot,
   input  logic [NUM_REQ-1:0][POS_W-1:0]       req_x,
   input  logic [NUM_REQ-1:0][POS_W-1:0]       req_y,
   input  logic [NUM_REQ-1:0]                  req_vis,
   output logic [NUM_REQ-1:0]                  ack,
   output logic [NUM_SLOTS-1:0][POS_W-1:0]     rect_x_pos,
   output logic [NUM_SLOTS-1:0][POS_W-1:0]     rect_y_pos,
   output logic [NUM_SLOTS-1:0]                slot_visible,
   output logic                                frame_update
);

   localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   pos_ctrl_state_t state_q, state_d;

   logic                            vblnk_q, commit;
   logic                            arb_en, do_copy, grant_valid;
   logic [NUM_REQ-1:0]              ack_q, grant, eligible;
   logic [RW-1:0]                   gidx;
   logic [SW-1:0]                   gslot;
   logic [NUM_SLOTS-1:0][POS_W-1:0] shx_q, shy_q, acx_q, acy_q;
   logic [NUM_SLOTS-1:0]            shv_q, acv_q;
   logic                            fu_q;

   assign commit   = vblnk & ~vblnk_q;
   assign eligible = req & ~ack_q;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .eligible    (eligible),
      .en          (arb_en),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) gidx = RW'(i);
   end
   assign gslot = req_slot[gidx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= PC_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PC_IDLE:   if (commit) state_d = PC_COMMIT;
         PC_COMMIT: state_d = PC_IDLE;
         default:   state_d = PC_IDLE;
      endcase
   end

   always_comb begin
      arb_en  = (state_q == PC_IDLE) && !commit;
      do_copy = (state_q == PC_COMMIT);
   end

   // vblnk_q resets high so a blank already in progress at release is not a commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vblnk_q <= 1'b1;
         ack_q   <= '0;
         fu_q    <= 1'b0;
         shx_q   <= '0;
         shy_q   <= '0;
         shv_q   <= '0;
         acx_q   <= '0;
         acy_q   <= '0;
         acv_q   <= '0;
      end else begin
         vblnk_q <= vblnk;
         ack_q   <= grant;
         fu_q    <= do_copy;
         if (grant_valid && (int'(gslot) < NUM_SLOTS)) begin
            shx_q[gslot] <= clamp_pos(req_x[gidx], X_MAX);
            shy_q[gslot] <= clamp_pos(req_y[gidx], Y_MAX);
            shv_q[gslot] <= req_vis[gidx];
         end
         if (do_copy) begin
            acx_q <= shx_q;
            acy_q <= shy_q;
            acv_q <= shv_q;
         end
      end
   end

   assign ack          = ack_q;
   assign rect_x_pos   = acx_q;
   assign rect_y_pos   = acy_q;
   assign slot_visible = acv_q;
   assign frame_update = fu_q;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Scoreboard bench for sprite_pos_ctrl: expected acks and committed frames are
// queued at stimulus time and compared when the DUT produces them.
module tb_sprite_pos_ctrl;

   localparam int NR = 4;
   localparam int NS = 4;
   localparam int XM = 960;
   localparam int YM = 704;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     vblnk;
   logic [NR-1:0]            req, req_vis, ack;
   logic [NR-1:0][1:0]       req_slot;
   logic [NR-1:0][11:0]      req_x, req_y;
   logic [NS-1:0][11:0]      rect_x_pos, rect_y_pos;
   logic [NS-1:0]            slot_visible;
   logic                     frame_update;

   typedef struct packed {
      logic [NS-1:0][11:0] x;
      logic [NS-1:0][11:0] y;
      logic [NS-1:0]       v;
   } frame_t;

   int     n_checks = 0;
   int     n_errors = 0;
   int     exp_ack_q[$];
   frame_t exp_frame_q[$];

   logic [NS-1:0][11:0] mx, my;
   logic [NS-1:0]       mv;

   always #5 clk = ~clk;

   sprite_pos_ctrl #(.NUM_REQ(NR), .NUM_SLOTS(NS), .X_MAX(XM), .Y_MAX(YM)) dut (
      .clk          (clk),
      .rst          (rst),
      .vblnk        (vblnk),
      .req          (req),
      .req_slot     (req_slot),
      .req_x        (req_x),
      .req_y        (req_y),
      .req_vis      (req_vis),
      .ack          (ack),
      .rect_x_pos   (rect_x_pos),
      .rect_y_pos   (rect_y_pos),
      .slot_visible (slot_visible),
      .frame_update (frame_update)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: pops scoreboard entries as acks and frame updates appear.
   logic [NR-1:0] prev_ack = '0;
   always @(negedge clk) begin
      frame_t f;
      int     r;
      if (rst) prev_ack = '0;
      else begin
         if (ack != '0) begin
            chk("ack_back_to_back", 64'(ack & prev_ack), 64'd0);
            if (exp_ack_q.size() == 0) chk("ack_unexpected", 64'(ack), 64'd0);
            else begin
               r = exp_ack_q.pop_front();
               chk("ack_order", 64'(ack), 64'(1 << r));
            end
         end
         if (frame_update) begin
            if (exp_frame_q.size() == 0) chk("frame_unexpected", 64'(frame_update), 64'd0);
            else begin
               f = exp_frame_q.pop_front();
               chk("frame_x", 64'(rect_x_pos), 64'(f.x));
               chk("frame_y", 64'(rect_y_pos), 64'(f.y));
               chk("frame_vis", 64'(slot_visible), 64'(f.v));
            end
         end
         prev_ack = ack;
      end
   end

   task automatic push_frame();
      frame_t f;
      f.x = mx;
      f.y = my;
      f.v = mv;
      exp_frame_q.push_back(f);
   endtask

   task automatic do_write(input int r, input int slot, input int x, input int y,
                           input logic vis, output int lat);
      req_slot[r] = 2'(slot);
      req_x[r]    = 12'(x);
      req_y[r]    = 12'(y);
      req_vis[r]  = vis;
      req[r]      = 1'b1;
      exp_ack_q.push_back(r);
      mx[slot] = 12'((x > XM) ? XM : x);
      my[slot] = 12'((y > YM) ? YM : y);
      mv[slot] = vis;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ack[r] && lat < 20);
      req[r] = 1'b0;
   endtask

   task automatic vblank_pulse();
      vblnk = 1'b1;
      push_frame();
      repeat (4) @(negedge clk);
      vblnk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, acks, cyc;
      rst = 1'b1; vblnk = 1'b1;
      req = '0; req_vis = '0; req_slot = '0; req_x = '0; req_y = '0;
      mx = '0; my = '0; mv = '0;
      #12;
      chk("rst_x", 64'(rect_x_pos), 64'd0);
      chk("rst_y", 64'(rect_y_pos), 64'd0);
      chk("rst_vis", 64'(slot_visible), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_fu", 64'(frame_update), 64'd0);
      @(negedge clk); rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("no_spurious_fu", 64'(frame_update), 64'd0);
      end
      vblnk = 1'b0;
      repeat (2) @(negedge clk);

      do_write(0, 1, 100, 50, 1'b1, lat);
      chk("ack_latency", 64'(lat), 64'd1);
      repeat (3) @(negedge clk);
      chk("hold_x_before_commit", 64'(rect_x_pos), 64'd0);
      chk("hold_vis_before_commit", 64'(slot_visible), 64'd0);
      vblank_pulse();
      chk("slot1_x", 64'(rect_x_pos[1]), 64'd100);
      chk("slot1_y", 64'(rect_y_pos[1]), 64'd50);
      chk("slot1_vis", 64'(slot_visible[1]), 64'd1);

      do_write(2, 2, 1023, 900, 1'b1, lat);
      vblank_pulse();
      chk("clamp_x", 64'(rect_x_pos[2]), 64'd960);
      chk("clamp_y", 64'(rect_y_pos[2]), 64'd704);

      // Request raised together with the vblank rise: stalls past COMMIT.
      vblnk = 1'b1;
      push_frame();
      do_write(1, 3, 333, 222, 1'b1, lat);
      chk("ack_after_commit_latency", 64'(lat), 64'd3);
      repeat (2) @(negedge clk);
      vblnk = 1'b0;
      repeat (2) @(negedge clk);
      chk("late_write_not_committed", 64'(rect_x_pos[3]), 64'd0);
      vblank_pulse();
      chk("late_write_x", 64'(rect_x_pos[3]), 64'd333);
      chk("late_write_y", 64'(rect_y_pos[3]), 64'd222);

      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_x", 64'(rect_x_pos), 64'd0);
      chk("arst_y", 64'(rect_y_pos), 64'd0);
      chk("arst_vis", 64'(slot_visible), 64'd0);
      chk("arst_ack", 64'(ack), 64'd0);
      chk("arst_fu", 64'(frame_update), 64'd0);
      mx = '0; my = '0; mv = '0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      for (int r = 0; r < NR; r++) begin
         req_slot[r] = 2'(r);
         req_x[r]    = 12'(10 + r);
         req_y[r]    = 12'(20 + r);
         req_vis[r]  = r[0];
         mx[r] = 12'(10 + r);
         my[r] = 12'(20 + r);
         mv[r] = r[0];
      end
      exp_ack_q.push_back(0);
      exp_ack_q.push_back(1);
      exp_ack_q.push_back(2);
      exp_ack_q.push_back(3);
      exp_ack_q.push_back(0);
      req = '1;
      acks = 0;
      cyc = 0;
      while (acks < 5 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (ack != '0) acks++;
      end
      req = '0;
      chk("rr_ack_count", 64'(acks), 64'd5);
      @(negedge clk);
      chk("rr_queue_drained", 64'(exp_ack_q.size()), 64'd0);
      vblank_pulse();

      repeat (3) @(negedge clk);
      chk("ack_scoreboard_empty", 64'(exp_ack_q.size()), 64'd0);
      chk("frame_scoreboard_empty", 64'(exp_frame_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sprite_pos_ctrl.md
# sprite_pos_ctrl

Frame-synchronous position controller for the `draw_image` sprite layers. It arbitrates position/visibility writes from up to `NUM_REQ` requesters (mouse, board logic, game FSM, …) onto `NUM_SLOTS` shadow registers, one write per cycle, round-robin. It commits shadow to active on the rising edge of vertical blanking, so sprites never move mid-frame. The active outputs drive the `rect_x_pos`/`rect_y_pos` inputs of the `draw_image` instances and the slot enables of the overlay mux.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `NUM_SLOTS`, 4, number of sprite slots (≥1)
- `X_MAX`, 960, largest legal x position (screen width − sprite width)
- `Y_MAX`, 704, largest legal y position

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  reset, asynchronous, active-high
- `vblnk`  in  1  vertical blank from the timing `vga_if`
- `req`  in  NUM_REQ  write request per requester; held until acked
- `req_slot`  in  NUM_REQ×$clog2(NUM_SLOTS)  target slot per requester
- `req_x`, `req_y`  in  NUM_REQ×12 each  requested position
- `req_vis`  in  NUM_REQ  requested visibility
- `ack`  out  NUM_REQ  one-cycle write-accepted pulse
- `rect_x_pos`, `rect_y_pos`  out  NUM_SLOTS×12 each  active positions
- `slot_visible`  out  NUM_SLOTS  active visibility
- `frame_update`  out  1  one-cycle pulse on commit

## Operation
- Edge detect: `vblnk_d` register; `commit = vblnk & ~vblnk_d`.
- FSM, 2 states:
  - IDLE: arbitrate and write.
  - COMMIT: entered on `commit`; lasts 1 cycle; then returns to IDLE.
- Eligible requester: `req[i] & ~ack[i]`. This masks a requester in its ack cycle, so a continuous requester is granted at most every other cycle.
- Round-robin arbitration: grant the first eligible index after `last_grant`, wrapping modulo NUM_REQ. Update `last_grant` on each grant.
- A grant writes the shadow slot `req_slot`: `x = min(req_x, X_MAX)`, `y = min(req_y, Y_MAX)`, `vis = req_vis`.
- An out-of-range `req_slot` (≥ NUM_SLOTS) is acked and discarded.
- No grant is made in a cycle where `commit` is high or the FSM is in COMMIT. Requests stall and are not lost.
- Commit copies all shadow slots to the active outputs and pulses `frame_update`.
- Writes to the same slot by different requesters before a commit: the last write wins.

## Timing
- Request sampled at edge N → shadow updated and `ack[i]` high during cycle N+1 (single cycle).
- `vblnk` rises before edge C → `commit` is seen at edge C; active outputs and `frame_update` update at edge C+1 (1-cycle latency from `vblnk_d`). `frame_update` is high for cycle C+1 only.
- A write granted at edge C−1 is included in the commit at edge C+1.
- Reset (asynchronous, any time):
  - All shadow and active registers = 0, `slot_visible` = 0, `ack` = 0, `frame_update` = 0.
  - `vblnk_d` = 1, so there is no spurious commit if `vblnk` is high when reset releases.
  - `last_grant` = NUM_REQ−1, so requester 0 wins first.
  - FSM = IDLE.
- Reset mid-handshake: the pending write is dropped and the requester re-requests.

## Structure
- `vga_pkg` gains `SPRITE_X_MAX` and `SPRITE_Y_MAX` (defaults for `X_MAX`/`Y_MAX`) and the `pos_ctrl_state_t` enum.
- One sub-module: `rr_arbiter` (parameter `N`; inputs `clk`, `rst`, `eligible[N]`, `en`; outputs one-hot `grant[N]`, `grant_valid`). It holds `last_grant`; `en` = IDLE & ~`commit`.
- The top level holds the shadow/active arrays, the edge detector, the FSM and the clamping.

## Test plan
- Reset release with `vblnk`=1 → no `frame_update`; all outputs 0.
- Req0 writes slot 1 (x=100, y=50, vis=1); `ack[0]` 1 cycle later. Outputs stay 0 until the next `vblnk` rise; then `rect_x_pos[1]`=100, `rect_y_pos[1]`=50, `slot_visible[1]`=1, with one `frame_update` pulse.
- Req0–req3 all held high → ack order 0,1,2,3,0; no requester acked in two consecutive cycles.
- Req2 writes x=1023, y=900 → after commit, x=960, y=704.
- Request raised in the same cycle `commit` is detected → ack delayed until after the COMMIT cycle. The value appears only at the following frame's commit.
- Async `rst` pulse mid-frame with slots populated → all outputs 0 immediately. The next grant goes to req0.
